pipelined_ones_counter: RTL

PIPELINED_ONES_COUNTER -- requirements
Module: pipelined_ones_counter

---
 rtl/pipelined_ones_counter_pkg.sv | 44 ++++
 rtl/pipelined_ones_counter_if.sv | 40 ++++
 rtl/pipelined_ones_counter_popcount_tree.sv | 59 +++++
 rtl/pipelined_ones_counter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/pipelined_ones_counter_pkg.sv
// rtl/pipelined_ones_counter_pkg.sv - shared constants, width helpers and FSM encoding
//
// Purpose : common definitions for the pipelined ones counter slice.
//           Holds the clog2 helper, the derived-width helpers used to size
//           the per-word count, word counter and accumulator, the default
//           parameter values and the FSM state encoding.
// Ports   : none (package).

package pipelined_ones_counter_pkg;

   localparam int DEF_DATA_W    = 127;
   localparam int DEF_FRAME_MAX = 255;

   // Smallest r with 2**r >= value; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r++;
      end
      return r;
   endfunction

   // Width of a per-word count able to hold 0..data_w.
   function automatic int cnt_width(input int data_w);
      return clog2(data_w + 1);
   endfunction

   // Width of a word counter able to hold 0..frame_max.
   function automatic int wc_width(input int frame_max);
      return clog2(frame_max + 1);
   endfunction

   // Accumulator width: one full word count per word, frame_max words.
   function automatic int acc_width(input int data_w, input int frame_max);
      return cnt_width(data_w) + wc_width(frame_max);
   endfunction

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/pipelined_ones_counter_if.sv
// rtl/pipelined_ones_counter_if.sv - word input and frame result handshake bundle
//
// Purpose : groups the word-input stream and the frame-result stream.
// Signals : in_valid/in_ready/in_data/in_last/count_zeros - word input
//           out_valid/out_ready/out_count/out_words/out_overflow - frame result
// Modports: master - producer of words and consumer of results
//           slave  - the counter itself

interface pipelined_ones_counter_if #(
   parameter int DATA_W    = 127,
   parameter int FRAME_MAX = 255
) ();
   import pipelined_ones_counter_pkg::*;

   localparam int WC_W  = wc_width(FRAME_MAX);
   localparam int ACC_W = acc_width(DATA_W, FRAME_MAX);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              count_zeros;

   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_count;
   logic [WC_W-1:0]   out_words;
   logic              out_overflow;

   modport master (
      output in_valid, in_data, in_last, count_zeros, out_ready,
      input  in_ready, out_valid, out_count, out_words, out_overflow
   );

   modport slave (
      input  in_valid, in_data, in_last, count_zeros, out_ready,
      output in_ready, out_valid, out_count, out_words, out_overflow
   );

endinterface

// File: rtl/pipelined_ones_counter_popcount_tree.sv
// rtl/pipelined_ones_counter_popcount_tree.sv - combinational popcount adder tree
//
// Purpose : popcount_add is a parametrised W-bit adder node; popcount_tree
//           builds a balanced binary tree of those adders over the input word.
//           Purely combinational, no state.
// Ports   : popcount_add  - a, b (W bits) in, sum (W bits) out
//           popcount_tree - in_data (DATA_W bits) in, count (CNT_W bits) out

module popcount_add #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum
);
   assign sum = a + b;
endmodule

module popcount_tree
   import pipelined_ones_counter_pkg::*;
#(
   parameter int DATA_W = 127
) (
   input  logic [DATA_W-1:0]            in_data,
   output logic [cnt_width(DATA_W)-1:0] count
);
   localparam int CNT_W  = cnt_width(DATA_W);
   localparam int LEVELS = clog2(DATA_W);
   localparam int N_LEAF = 1 << LEVELS;

   // Every node is CNT_W wide: a subtree never sums more than DATA_W bits,
   // so no node can exceed the final width. Leaves beyond DATA_W are zero.
   genvar l, n;
   for (l = 0; l <= LEVELS; l++) begin : g_lvl
      localparam int NODES = N_LEAF >> l;
      logic [CNT_W-1:0] sum [NODES];

      if (l == 0) begin : g_leaf
         for (n = 0; n < NODES; n++) begin : g_bit
            if (n < DATA_W) begin : g_data
               assign sum[n] = CNT_W'(in_data[n]);
            end else begin : g_pad
               assign sum[n] = '0;
            end
         end
      end else begin : g_node
         for (n = 0; n < NODES; n++) begin : g_add
            popcount_add #(.W(CNT_W)) u_add (
               .a   (g_lvl[l-1].sum[2*n]),
               .b   (g_lvl[l-1].sum[2*n+1]),
               .sum (sum[n])
            );
         end
      end
   end

   assign count = g_lvl[LEVELS].sum[0];

endmodule

// File: rtl/pipelined_ones_counter.sv
// rtl/pipelined_ones_counter.sv - framed, two-stage pipelined ones/zeros counter
//
// Purpose : accepts words of a frame, counts ones (or zeros) per word, and
//           accumulates the frame total. Stage 1 registers the per-word
//           count, stage 2 adds it into the accumulator. A frame ends on
//           in_last or when it reaches FRAME_MAX words (flagged overflow).
//           The result is held until the consumer takes it; only then is a
//           new frame accepted.
// Ports   : clk   - clock, rising edge
//           rst_n - synchronous active-low reset
//           bus   - pipelined_ones_counter_if.slave (word input, frame result)

module pipelined_ones_counter
   import pipelined_ones_counter_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int FRAME_MAX = DEF_FRAME_MAX
) (
   input  logic                    clk,
   input  logic                    rst_n,
   pipelined_ones_counter_if.slave bus
);
   localparam int CNT_W = cnt_width(DATA_W);
   localparam int WC_W  = wc_width(FRAME_MAX);
   localparam int ACC_W = acc_width(DATA_W, FRAME_MAX);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             in_ready_q;
   logic             mode_q;
   logic             s1_valid;
   logic             s1_last;
   logic [CNT_W-1:0] s1_count;
   logic [ACC_W-1:0] acc;
   logic [WC_W-1:0]  word_cnt;
   logic             ovf_q;

   logic [CNT_W-1:0] pop;
   logic [CNT_W-1:0] word_val;
   logic [WC_W-1:0]  word_cnt_nxt;
   logic             accept;
   logic             mode_eff;
   logic             hit_max;
   logic             frame_end;

   popcount_tree #(.DATA_W(DATA_W)) u_pop (
      .in_data (bus.in_data),
      .count   (pop)
   );

   assign accept   = bus.in_valid && in_ready_q;

   // The mode is taken live on the first word of a frame, then latched.
   assign mode_eff = (state == ST_IDLE) ? bus.count_zeros : mode_q;
   assign word_val = mode_eff ? (CNT_W'(DATA_W) - pop) : pop;

   // word_cnt is zero in IDLE, so the same increment serves the first word.
   assign word_cnt_nxt = word_cnt + WC_W'(1);
   assign hit_max      = (word_cnt_nxt == WC_W'(FRAME_MAX));
   assign frame_end    = bus.in_last || hit_max;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = frame_end ? ST_DRAIN : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (accept && frame_end) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // The last word's count is summed on this same edge.
            if (s1_valid && s1_last) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         in_ready_q <= 1'b0;
         mode_q     <= 1'b0;
         s1_valid   <= 1'b0;
         s1_last    <= 1'b0;
         s1_count   <= '0;
         acc        <= '0;
         word_cnt   <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state      <= state_nxt;
         // Registered so it stays low through reset and rises one edge later.
         in_ready_q <= (state_nxt == ST_IDLE) || (state_nxt == ST_ACCUM);

         s1_valid   <= accept;
         s1_last    <= accept && frame_end;
         if (accept) begin
            s1_count <= word_val;
            mode_q   <= mode_eff;
            word_cnt <= word_cnt_nxt;
            if (hit_max) begin
               ovf_q <= 1'b1;
            end
         end

         if (s1_valid) begin
            acc <= acc + ACC_W'(s1_count);
         end

         // Clearing at the result handshake leaves IDLE ready for a new frame.
         if ((state == ST_DONE) && bus.out_ready) begin
            acc      <= '0;
            word_cnt <= '0;
            ovf_q    <= 1'b0;
         end
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.out_valid    = (state == ST_DONE);
   assign bus.out_count    = acc;
   assign bus.out_words    = word_cnt;
   assign bus.out_overflow = ovf_q;

endmodule
